prbs_gen: RTL and testbench

PRBS_GEN -- requirements
Module: prbs_gen

---
 rtl/prbs_gen.sv | 165 ++++++++++++++++
 tb/tb_prbs_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen.sv
// Multi-mode Fibonacci PRBS generator (PRBS7/9/15/23/31) emitting NB_OUT bits per advance.
// Seeds are masked to the active length; an all-zero seed is replaced by 1 and flagged.
//
// state   | meaning
// ST_RST  | held in reset, LFSR cleared
// ST_INIT | one cycle, loads the masked power-up SEED
// ST_RUN  | normal operation: seed loads, mode reloads, advances
module prbs_gen #(
    parameter int                  NB_OUT    = 1,
    parameter int                  NB_STATE  = 31,
    parameter logic [NB_STATE-1:0] SEED      = 31'h0000_01AA,
    parameter logic [1:0]          ADV_PHASE = 2'b11
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_EnbTx,
    input  logic [1:0]          i_enable_sample,
    input  logic [2:0]          i_mode,
    input  logic                i_seed_load,
    input  logic [NB_STATE-1:0] i_seed,
    input  logic                i_err_inject,
    output logic [NB_OUT-1:0]   o_data,
    output logic                o_valid,
    output logic                o_lockup
);

    localparam int IW = $clog2(NB_STATE);

    typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_t;

    state_t              fsm_q, fsm_d;
    logic [NB_STATE-1:0] lfsr_q, lfsr_d;
    logic [NB_OUT-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                lock_q, lock_d;
    logic [2:0]          mode_q, mode_d;

    logic                ld_en, adv;
    logic [NB_STATE-1:0] ld_src, ld_val, s;
    logic [2:0]          ld_mode;
    logic [IW-1:0]       msb, tap;
    logic                fb;
    logic [NB_OUT-1:0]   word;

    // Codes 5..7 fall back to PRBS9.
    function automatic logic [NB_STATE-1:0] mode_mask(input logic [2:0] m);
        case (m)
            3'd0:    mode_mask = NB_STATE'(32'h0000_007F);
            3'd2:    mode_mask = NB_STATE'(32'h0000_7FFF);
            3'd3:    mode_mask = NB_STATE'(32'h007F_FFFF);
            3'd4:    mode_mask = NB_STATE'(32'h7FFF_FFFF);
            default: mode_mask = NB_STATE'(32'h0000_01FF);
        endcase
    endfunction

    function automatic logic [IW-1:0] mode_msb(input logic [2:0] m);
        case (m)
            3'd0:    mode_msb = IW'(6);
            3'd2:    mode_msb = IW'(14);
            3'd3:    mode_msb = IW'(22);
            3'd4:    mode_msb = IW'(30);
            default: mode_msb = IW'(8);
        endcase
    endfunction

    function automatic logic [IW-1:0] mode_tap(input logic [2:0] m);
        case (m)
            3'd0:    mode_tap = IW'(5);
            3'd2:    mode_tap = IW'(13);
            3'd3:    mode_tap = IW'(17);
            3'd4:    mode_tap = IW'(27);
            default: mode_tap = IW'(4);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (i_rst) begin
            fsm_q   <= ST_RST;
            lfsr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
            mode_q  <= i_mode;
        end else begin
            fsm_q   <= fsm_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            lock_q  <= lock_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_RST:  fsm_d = ST_INIT;
            ST_INIT: fsm_d = ST_RUN;
            ST_RUN:  fsm_d = ST_RUN;
            default: fsm_d = ST_RST;
        endcase
    end

    // Seed load beats mode change, which beats an advance.
    always_comb begin
        ld_en   = 1'b0;
        ld_src  = SEED;
        ld_mode = mode_q;
        adv     = 1'b0;
        mode_d  = mode_q;
        case (fsm_q)
            ST_INIT: ld_en = 1'b1;
            ST_RUN: begin
                if (i_seed_load) begin
                    ld_en  = 1'b1;
                    ld_src = i_seed;
                end else if (i_mode != mode_q) begin
                    ld_en   = 1'b1;
                    mode_d  = i_mode;
                    ld_mode = i_mode;
                end else begin
                    adv = i_EnbTx && (i_enable_sample == ADV_PHASE);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        lfsr_d  = lfsr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        lock_d  = lock_q;
        ld_val  = ld_src & mode_mask(ld_mode);
        msb     = mode_msb(mode_q);
        tap     = mode_tap(mode_q);
        s       = lfsr_q;
        word    = '0;
        fb      = 1'b0;
        for (int k = 0; k < NB_OUT; k++) begin
            word = (word << 1) | NB_OUT'(s[msb]);
            fb   = s[msb] ^ s[tap];
            s    = {s[NB_STATE-2:0], fb} & mode_mask(mode_q);
        end
        if (ld_en) begin
            if (ld_val == '0) begin
                lfsr_d = NB_STATE'(1);
                lock_d = 1'b1;
            end else begin
                lfsr_d = ld_val;
                lock_d = 1'b0;
            end
        end else if (adv) begin
            lfsr_d             = s;
            data_d             = word;
            data_d[NB_OUT-1]   = word[NB_OUT-1] ^ i_err_inject;
            valid_d            = 1'b1;
        end
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_lockup = lock_q;

endmodule

// File: tb/tb_prbs_gen.sv
// Self-checking bench for prbs_gen: NB_OUT=1 and NB_OUT=8 instances share stimulus and are
// compared every cycle against an output-stream recurrence model b[n+L] = b[n] ^ b[n+L-T].
module tb_prbs_gen;

    localparam logic [30:0] SEED_P = 31'h0000_01AA;

    logic        clk = 1'b0;
    logic        rst, enb, seed_load, err;
    logic [1:0]  phase;
    logic [2:0]  mode;
    logic [30:0] seed;
    logic        d1, v1, l1, v8, l8;
    logic [7:0]  d8;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    prbs_gen #(.NB_OUT(1)) u_dut1 (
        .clk(clk), .i_rst(rst), .i_EnbTx(enb), .i_enable_sample(phase), .i_mode(mode),
        .i_seed_load(seed_load), .i_seed(seed), .i_err_inject(err),
        .o_data(d1), .o_valid(v1), .o_lockup(l1)
    );

    prbs_gen #(.NB_OUT(8)) u_dut8 (
        .clk(clk), .i_rst(rst), .i_EnbTx(enb), .i_enable_sample(phase), .i_mode(mode),
        .i_seed_load(seed_load), .i_seed(seed), .i_err_inject(err),
        .o_data(d8), .o_valid(v8), .o_lockup(l8)
    );

    // Model: h[d][0..L-1] holds the next L output bits of instance d, oldest first.
    int         m_phase;
    logic [2:0] m_mode;
    bit         h[2][31];
    bit         m_lock[2];
    bit         m_valid[2];
    logic [7:0] m_data[2];

    function automatic int len_of(input logic [2:0] m);
        case (m)
            3'd0: return 7;
            3'd2: return 15;
            3'd3: return 23;
            3'd4: return 31;
            default: return 9;
        endcase
    endfunction

    function automatic int tap_of(input logic [2:0] m);
        case (m)
            3'd0: return 6;
            3'd2: return 14;
            3'd3: return 18;
            3'd4: return 28;
            default: return 5;
        endcase
    endfunction

    task automatic m_load(input int d, input logic [30:0] v, input logic [2:0] m);
        int          L;
        logic [31:0] msk;
        logic [30:0] x;
        L   = len_of(m);
        msk = (32'd1 << L) - 32'd1;
        x   = v & msk[30:0];
        if (x == 31'd0) begin
            x = 31'd1;
            m_lock[d] = 1'b1;
        end else begin
            m_lock[d] = 1'b0;
        end
        for (int i = 0; i < 31; i++) h[d][i] = (i < L) ? x[L-1-i] : 1'b0;
    endtask

    task automatic m_adv(input int d, input int nb, input bit e);
        int         L, T;
        bit         b, nb_bit;
        logic [7:0] w;
        L = len_of(m_mode);
        T = tap_of(m_mode);
        w = 8'd0;
        for (int k = 0; k < nb; k++) begin
            b      = h[d][0];
            nb_bit = b ^ h[d][L-T];
            for (int i = 0; i < L - 1; i++) h[d][i] = h[d][i+1];
            h[d][L-1] = nb_bit;
            w = {w[6:0], b};
        end
        w[nb-1]    = w[nb-1] ^ e;
        m_data[d]  = w;
        m_valid[d] = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_mode  = mode;
            for (int d = 0; d < 2; d++) begin
                m_data[d]  = 8'd0;
                m_valid[d] = 1'b0;
                m_lock[d]  = 1'b0;
                for (int i = 0; i < 31; i++) h[d][i] = 1'b0;
            end
        end else begin
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_load(0, SEED_P, m_mode);
                m_load(1, SEED_P, m_mode);
                m_phase = 2;
            end else if (seed_load) begin
                m_load(0, seed, m_mode);
                m_load(1, seed, m_mode);
            end else if (mode != m_mode) begin
                m_mode = mode;
                m_load(0, SEED_P, m_mode);
                m_load(1, SEED_P, m_mode);
            end else if (enb && phase == 2'b11) begin
                m_adv(0, 1, err);
                m_adv(1, 8, err);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("d1_data", 32'(d1), 32'(m_data[0][0]));
            check("d1_valid", 32'(v1), 32'(m_valid[0]));
            check("d1_lockup", 32'(l1), 32'(m_lock[0]));
            check("d8_data", 32'(d8), 32'(m_data[1]));
            check("d8_valid", 32'(v8), 32'(m_valid[1]));
            check("d8_lockup", 32'(l8), 32'(m_lock[1]));
        end
    end

    bit         log1[$];
    logic [7:0] log8[$];

    task automatic step();
        @(negedge clk);
        if (v1) log1.push_back(d1);
        if (v8) log8.push_back(d8);
    endtask

    task automatic collect(input int n1, input int n8, input int budget);
        int c;
        c = 0;
        while ((log1.size() < n1 || log8.size() < n8) && c < budget) begin
            step();
            c++;
        end
        if (log1.size() < n1 || log8.size() < n8) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout: got %0d/%0d words expected %0d/%0d", log1.size(),
                     log8.size(), n1, n8);
        end
    endtask

    task automatic period_check(input logic [2:0] m);
        int L, P, bad, zero_w, early;
        bit same, allz;
        L = len_of(m);
        P = (1 << L) - 1;
        mode = m;
        step();
        log1.delete();
        log8.delete();
        collect(P + L, 0, P + L + 50);
        if (log1.size() >= P + L) begin
            bad = 0;
            for (int i = 0; i < L; i++) if (log1[P+i] != log1[i]) bad++;
            check($sformatf("period_m%0d", m), bad, 0);
            zero_w = 0;
            early  = 0;
            for (int k = 0; k < P; k++) begin
                same = 1'b1;
                allz = 1'b1;
                for (int i = 0; i < L; i++) begin
                    if (log1[k+i] != log1[i]) same = 1'b0;
                    if (log1[k+i]) allz = 1'b0;
                end
                if (allz) zero_w++;
                if (same && k > 0) early++;
            end
            check($sformatf("state_nonzero_m%0d", m), zero_w, 0);
            check($sformatf("period_min_m%0d", m), early, 0);
        end
    endtask

    initial begin
        bit         exp9[14];
        bit         exp7[8];
        logic [7:0] exp31[4];
        int         cnt;

        exp9  = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
        exp7  = '{0, 1, 0, 1, 0, 1, 0, 1};
        exp31 = '{8'h00, 8'h00, 8'h03, 8'h54};

        rst = 1'b1; enb = 1'b1; phase = 2'b11; mode = 3'd1;
        seed_load = 1'b0; seed = '0; err = 1'b0;
        step();
        chk_on = 1'b1;
        repeat (2) step();
        check("rst_data", 32'(d8), 32'd0);
        check("rst_valid", 32'(v1), 32'd0);
        check("rst_lockup", 32'(l1), 32'd0);

        // Power-up sequence, PRBS9 from SEED
        rst = 1'b0;
        log1.delete();
        log8.delete();
        collect(14, 0, 40);
        if (log1.size() >= 14)
            for (int i = 0; i < 14; i++) check($sformatf("powerup_bit%0d", i), 32'(log1[i]), 32'(exp9[i]));

        // Gating
        phase = 2'b01;
        cnt = 0;
        repeat (6) begin step(); cnt += int'(v1); end
        check("gate_phase01", cnt, 0);
        enb = 1'b0; phase = 2'b11;
        cnt = 0;
        repeat (6) begin step(); cnt += int'(v1); end
        check("gate_enbtx0", cnt, 0);
        enb = 1'b1;
        step();
        cnt = int'(v1);
        enb = 1'b0;
        repeat (4) begin step(); cnt += int'(v1); end
        check("gate_one_pulse", cnt, 1);

        // Seed loads and lockup
        enb = 1'b1; seed_load = 1'b1; seed = 31'd0;
        step();
        check("load_no_valid", 32'(v1), 32'd0);
        check("zero_seed_lockup", 32'(l1), 32'd1);
        seed_load = 1'b0;
        step();
        check("state_one_bit", 32'(d1), 32'd0);
        check("state_one_word", 32'(d8), 32'h00);
        seed_load = 1'b1; seed = 31'h1FF;
        step();
        check("lockup_clear", 32'(l8), 32'd0);
        seed_load = 1'b0; err = 1'b1;
        step();
        check("err_bit", 32'(d1), 32'd0);
        check("err_word", 32'(d8), 32'h7F);
        err = 1'b0;
        step();
        check("post_err_bit", 32'(d1), 32'd1);
        check("post_err_word", 32'(d8), 32'h83);

        // Mode switch 1->0 and periods
        period_check(3'd0);
        for (int i = 0; i < 8; i++) check($sformatf("prbs7_bit%0d", i), 32'(log1[i]), 32'(exp7[i]));
        period_check(3'd1);
        period_check(3'd2);

        // Width equivalence on PRBS31
        mode = 3'd4;
        step();
        log1.delete();
        log8.delete();
        collect(0, 4, 20);
        if (log8.size() >= 4)
            for (int i = 0; i < 4; i++) check($sformatf("prbs31_word%0d", i), 32'(log8[i]), 32'(exp31[i]));

        // Randomized traffic including mid-word resets
        repeat (1500) begin
            rst       = ($urandom_range(0, 149) == 0);
            enb       = ($urandom_range(0, 3) != 0);
            phase     = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            err       = ($urandom_range(0, 5) == 0);
            seed_load = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0: seed = 31'd0;
                1: seed = 31'h4000_0000;
                default: seed = 31'($urandom);
            endcase
            if ($urandom_range(0, 59) == 0) mode = 3'($urandom);
            step();
        end
        rst = 1'b0; seed_load = 1'b0; err = 1'b0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
